// File: rtl/mts_sysref_ctrl.sv
// Multi-channel MTS sysref controller: synchronises PL sysref, measures its period,
// declares lock and issues per-channel delayed one-cycle user_sysref pulses.
module mts_sysref_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16,
  parameter int LOCK_CNT    = 4,
  parameter int DELAY_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sysref_in,
  input  logic                        arm,
  input  logic                        continuous,
  input  logic [PERIOD_W-1:0]         expected_period,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [NUM_CH*DELAY_W-1:0]   ch_delay,
  output logic [NUM_CH-1:0]           user_sysref,
  output logic                        locked,
  output logic [PERIOD_W-1:0]         period_meas,
  output logic                        err_period,
  output logic                        capture_done,
  output logic [1:0]                  state
);
  localparam int GOOD_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LOCK = 2'd1, ARMED = 2'd2, RUN = 2'd3} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_d_reg, edge_reg, seen_reg;
  logic [PERIOD_W-1:0]    cnt_reg, period_meas_reg, period_now;
  logic [GOOD_W-1:0]      good_reg;
  logic                   locked_reg, err_reg, capture_done_reg;
  logic                   edge_match, fire, capture_next, err_set, err_clr;

  // Edge is registered so the measurement lands at E(SYNC_STAGES+1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sysref_in};
      s_d_reg  <= sync_reg[SYNC_STAGES-1];
      edge_reg <= sync_reg[SYNC_STAGES-1] & ~s_d_reg;
    end
  end

  assign period_now = (cnt_reg == '1) ? '1 : cnt_reg + PERIOD_W'(1);
  assign edge_match = edge_reg & seen_reg & (period_now == expected_period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      seen_reg        <= 1'b0;
      period_meas_reg <= '0;
      good_reg        <= '0;
      locked_reg      <= 1'b0;
    end else begin
      if (edge_reg) begin
        cnt_reg  <= '0;
        seen_reg <= 1'b1;
        if (seen_reg) begin
          period_meas_reg <= period_now;
          if (period_now == expected_period)
            good_reg <= (good_reg == GOOD_W'(LOCK_CNT)) ? good_reg : good_reg + GOOD_W'(1);
          else
            good_reg <= '0;
        end
      end else if (cnt_reg != '1) begin
        cnt_reg <= cnt_reg + PERIOD_W'(1);
      end else begin
        good_reg <= '0;  // no sysref for a full counter span
      end
      locked_reg <= (good_reg == GOOD_W'(LOCK_CNT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (arm) state_next = WAIT_LOCK;
      WAIT_LOCK: if (locked_reg) state_next = ARMED;
      ARMED: begin
        if (!locked_reg)     state_next = IDLE;
        else if (edge_match) state_next = continuous ? RUN : IDLE;
      end
      RUN:       if (!locked_reg || !continuous) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    fire         = 1'b0;
    capture_next = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    unique case (state_reg)
      IDLE: err_clr = arm;
      ARMED: begin
        if (!locked_reg) err_set = 1'b1;
        else if (edge_match) begin
          fire         = 1'b1;
          capture_next = ~continuous;
        end
      end
      RUN: begin
        if (!locked_reg)                  err_set = 1'b1;
        else if (continuous && edge_match) fire   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg          <= 1'b0;
      capture_done_reg <= 1'b0;
    end else begin
      capture_done_reg <= capture_next;
      if (err_clr)      err_reg <= 1'b0;
      else if (err_set) err_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DELAY_W-1:0] dly_in, dly_reg;
      logic               pend_reg, pulse_reg;

      assign dly_in = ch_delay[gi*DELAY_W +: DELAY_W];

      // A new fire always reloads, so the latest fire wins over a pending one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_reg   <= '0;
          pend_reg  <= 1'b0;
          pulse_reg <= 1'b0;
        end else if (fire) begin
          if (dly_in == '0) begin
            pulse_reg <= ch_enable[gi];
            pend_reg  <= 1'b0;
          end else begin
            pulse_reg <= 1'b0;
            pend_reg  <= ch_enable[gi];
            dly_reg   <= dly_in - DELAY_W'(1);
          end
        end else if (pend_reg) begin
          if (dly_reg == '0) begin
            pulse_reg <= 1'b1;
            pend_reg  <= 1'b0;
          end else begin
            pulse_reg <= 1'b0;
            dly_reg   <= dly_reg - DELAY_W'(1);
          end
        end else begin
          pulse_reg <= 1'b0;
        end
      end

      assign user_sysref[gi] = pulse_reg;
    end
  endgenerate

  assign locked       = locked_reg;
  assign period_meas  = period_meas_reg;
  assign err_period   = err_reg;
  assign capture_done = capture_done_reg;
  assign state        = state_reg;
endmodule

// File: doc/mts_sysref_ctrl.md
# mts_sysref_ctrl

Parametrised successor to the fixed two-output MTS sysref synchroniser. It samples the buffered PL sysref in the single PL reference-clock domain through a configurable synchroniser and measures the sysref period. It declares lock after a run of correct periods, then issues per-channel, per-channel-delayed one-cycle `user_sysref` pulses to `NUM_CH` converter tiles, either once per arm or continuously. It sits between the differential-to-single sysref buffer and the RFdc user-sysref inputs.

## Interface
- `NUM_CH`, 2: number of `user_sysref` output channels (ADC, DAC, ...).
- `SYNC_STAGES`, 2: synchroniser flops on `sysref_in` (min 2).
- `PERIOD_W`, 16: width of the period counter and period values.
- `LOCK_CNT`, 4: consecutive matching periods required for lock (1..15).
- `DELAY_W`, 4: per-channel delay field width.

- `clk`  in  1  PL reference clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sysref_in`  in  1  buffered sysref, asynchronous to `clk`.
- `arm`  in  1  one-cycle request; honoured only in IDLE.
- `continuous`  in  1  1 = pulse on every edge after arm; 0 = single capture.
- `expected_period`  in  PERIOD_W  expected sysref period in `clk` cycles (≥ 2^DELAY_W + 2).
- `ch_enable`  in  NUM_CH  per-channel output enable.
- `ch_delay`  in  NUM_CH*DELAY_W  channel i delay at bits [i*DELAY_W +: DELAY_W].
- `user_sysref`  out  NUM_CH  per-channel sysref pulses.
- `locked`  out  1  period lock status.
- `period_meas`  out  PERIOD_W  last measured period.
- `err_period`  out  1  sticky: lock lost while armed or running.
- `capture_done`  out  1  one-cycle pulse at the end of a single capture.
- `state`  out  2  IDLE=0, WAIT_LOCK=1, ARMED=2, RUN=3.

## Operation
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0, first-edge flag clear.
- The synchroniser output `s` feeds a registered `s_d`. `edge = s & ~s_d` is the only sysref event.
- Period counter `cnt` increments every cycle and saturates at all-ones.
  - On `edge`: `cnt <= 0`.
  - On `edge`, if an edge has been seen since reset, `period_meas <= cnt + 1`, saturating.
  - The first edge after reset only sets the first-edge flag.
- Lock counter `good`:
  - A measured period equal to `expected_period` increments `good`, saturating at LOCK_CNT.
  - Any mismatch clears `good`.
  - `cnt` reaching all-ones clears `good`. This is the no-sysref timeout.
- `locked = (good == LOCK_CNT)`, registered.
- FSM:
  - IDLE: on `arm`, clear `err_period` and go to WAIT_LOCK.
  - WAIT_LOCK: when `locked` = 1, go to ARMED.
  - ARMED: on `edge`, fire all channels.
    - With `continuous` = 0: pulse `capture_done` and go to IDLE.
    - With `continuous` = 1: go to RUN.
  - RUN: fire all channels on every `edge`. Go to IDLE when `continuous` drops.
  - ARMED or RUN, `locked` falls: set `err_period`, go to IDLE, fire nothing that cycle.
- `arm` outside IDLE is ignored.
- Fire:
  - Channel i latches `ch_enable[i]` and its delay, and loads a down-counter.
  - `user_sysref[i]` is high for exactly one cycle, `ch_delay[i]` cycles after the fire cycle.
  - A fire while channel i is still pending restarts that channel's countdown; the latest fire wins.
  - A disabled channel stays 0.
- `ch_delay` and `ch_enable` changes affect only subsequent fires.

## Timing
- Edge numbering: clock edge E0 is the first edge at which `sysref_in` = 1 is sampled.
- Edge pulse and measurements:
  - `edge` is valid in the cycle after E(SYNC_STAGES).
  - `period_meas` and `good` update at E(SYNC_STAGES+1).
  - `locked` updates one edge later.
- Channel with delay d: `user_sysref[i]` is high from E(SYNC_STAGES+1+d) to E(SYNC_STAGES+2+d).
  - Total latency is SYNC_STAGES+1+d cycles.
  - Channel-to-channel skew equals the delay difference exactly.
- `capture_done` and the state change are registered at the same edge as the fire (E(SYNC_STAGES+1)).
- `err_period` is set at the edge after `locked` falls.
- `rst_n` asserted mid-pulse forces `user_sysref` to 0 immediately, without waiting for a clock edge.

## Test plan
- Lock acquisition:
  - Stimulus: expected_period=32, sysref period 32 (16 high), LOCK_CNT=4.
  - Required: period_meas=32 from the 2nd edge; locked=1 one cycle after the 5th edge's measurement; locked stays 0 before that.
- Single capture:
  - Stimulus: locked, ch_delay={3,0}, continuous=0, arm.
  - Required: state 1→2. On the next edge, user_sysref[0] fires at latency SYNC_STAGES+1 and user_sysref[1] 3 cycles later. capture_done pulses once; state returns to 0. No further pulses on later edges.
- Continuous and loss:
  - Stimulus: continuous=1, run 3 edges, then one period of 33.
  - Required: 3 pulses per channel. locked falls, err_period=1, state=0, no pulse on the mismatched edge. A later arm clears err_period.
- Timeout:
  - Stimulus: locked, then sysref held low, PERIOD_W=8.
  - Required: locked falls 256 cycles after the last edge (counter saturation); period_meas unchanged.
- Masking and ignored arm:
  - Stimulus: ch_enable=2'b01; arm pulsed while in RUN.
  - Required: user_sysref[1] stays 0; the arm in RUN has no effect on state or err_period.
- Async reset:
  - Stimulus: rst_n low in RUN during a pending delay.
  - Required: all outputs 0 at once; state=0; after release, locked requires LOCK_CNT+1 new edges.
